vga_fetch_scheduler: RTL and testbench

// Sequences line fetches for the AXI-full VGA read master over one frame.
// - Issues one fetch request per display line into the ping-pong line BRAMs.
// - Tracks buffer occupancy and computes each fetch start address.
// - Flags display underrun.
// - Position: between the VGA timing/reader logic and the master's VGA_READY / AXI_VGA_READY / start-address pins.

---
 rtl/vga_fetch_pkg.sv | 16 +
 rtl/vga_buf_tracker.sv | 67 ++++++
 rtl/vga_fetch_scheduler.sv | 149 ++++++++++++++
 tb/tb_vga_fetch_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types for the VGA line-fetch scheduler.
// State encoding and ping-pong buffer depth.
package vga_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_ISSUE,
    S_WAIT_DONE,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [1:0] BUF_MAX = 2'd2;

endpackage

// File: rtl/vga_buf_tracker.sv
// Ping-pong line buffer occupancy, display buffer select,
// master fill-buffer shadow and sticky underrun flag.
module vga_buf_tracker
  import vga_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idle,
  input  logic       inc,
  input  logic       dec,
  input  logic       drain,
  input  logic       clr,
  input  logic       frame_start,
  output logic [1:0] level,
  output logic [1:0] level_nxt,
  output logic       active_buf,
  output logic       underrun
);

  logic [1:0] level_q;
  logic       active_q;
  logic       fill_q;
  logic       und_q;
  logic       fill_nxt;
  logic       act_nxt;

  // fill_q mirrors the master's own buffer flag, so drained fetches count
  always_comb begin
    fill_nxt  = fill_q ^ (inc | drain);
    level_nxt = level_q;
    act_nxt   = active_q;
    if (idle) begin
      level_nxt = '0;
    end else if (frame_start) begin
      level_nxt = '0;
      act_nxt   = fill_nxt;
    end else if (dec && level_q != '0) begin
      act_nxt = ~active_q;
      if (!inc)
        level_nxt = level_q - 2'd1;
    end else if (inc && level_q != BUF_MAX) begin
      level_nxt = level_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      active_q <= 1'b0;
      fill_q   <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      level_q  <= level_nxt;
      active_q <= act_nxt;
      fill_q   <= fill_nxt;
      if (dec && level_q == '0)
        und_q <= 1'b1;
      else if (clr)
        und_q <= 1'b0;
    end
  end

  assign level      = level_q;
  assign active_buf = active_q;
  assign underrun   = und_q;

endmodule

// File: rtl/vga_fetch_scheduler.sv
// Per-line fetch sequencer for the AXI VGA read master:
// request pacing, start address and frame line count.
module vga_fetch_scheduler
  import vga_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int FETCH_BYTES     = 3328,
  parameter int LINES_PER_FRAME = 480,
  parameter int LINE_IDX_WIDTH  = 10
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      ENABLE,
  input  logic [ADDR_WIDTH-1:0]     FRAME_BASE_ADDR,
  input  logic                      VSYNC_START,
  input  logic                      LINE_DONE,
  input  logic                      FETCH_DONE,
  input  logic                      CLR_UNDERRUN,
  output logic                      FETCH_REQ,
  output logic [ADDR_WIDTH-1:0]     FETCH_ADDR,
  output logic                      ACTIVE_BUF,
  output logic [1:0]                BUF_LEVEL,
  output logic [LINE_IDX_WIDTH-1:0] LINE_IDX,
  output logic                      FRAME_DONE,
  output logic                      UNDERRUN,
  output logic                      BUSY
);

  state_t                    state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]     base_q, addr_q, base_src;
  logic [LINE_IDX_WIDTH-1:0] idx_q;
  logic                      req_q, fd_q, fd_nxt, busy_q;
  logic                      vpend_q, vpend_nxt;
  logic                      inc, drain, fstart, last;
  logic [1:0]                level_nxt;

  assign last = idx_q == LINE_IDX_WIDTH'(LINES_PER_FRAME - 1);

  always_comb begin
    inc      = FETCH_DONE && state_q == S_WAIT_DONE;
    drain    = FETCH_DONE && state_q == S_DRAIN;
    base_src = VSYNC_START ? FRAME_BASE_ADDR : base_q;
    fstart   = 1'b0;
    unique case (state_q)
      S_WAIT_VSYNC,
      S_HOLD:      fstart = ENABLE && VSYNC_START;
      S_WAIT_DONE: fstart = inc && ENABLE && VSYNC_START;
      S_DRAIN:     fstart = drain && ENABLE && (vpend_q || VSYNC_START);
      default:     fstart = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    fd_nxt    = 1'b0;
    vpend_nxt = vpend_q;
    unique case (state_q)
      S_IDLE:
        if (ENABLE) state_nxt = S_WAIT_VSYNC;
      S_WAIT_VSYNC:
        if (!ENABLE)    state_nxt = S_IDLE;
        else if (fstart) state_nxt = S_ISSUE;
      S_ISSUE:
        state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:
        if (inc) begin
          if (!ENABLE)
            state_nxt = S_IDLE;
          else if (fstart)
            state_nxt = S_ISSUE;
          else if (last) begin
            fd_nxt    = 1'b1;
            state_nxt = S_WAIT_VSYNC;
          end else if (level_nxt < BUF_MAX)
            state_nxt = S_ISSUE;
          else
            state_nxt = S_HOLD;
        end else if (VSYNC_START || !ENABLE) begin
          state_nxt = S_DRAIN;
          vpend_nxt = VSYNC_START;
        end
      S_HOLD:
        if (!ENABLE)
          state_nxt = S_IDLE;
        else if (fstart || level_nxt < BUF_MAX)
          state_nxt = S_ISSUE;
      S_DRAIN:
        if (drain) begin
          vpend_nxt = 1'b0;
          state_nxt = fstart ? S_ISSUE : S_IDLE;
        end else if (VSYNC_START) begin
          vpend_nxt = 1'b1;
        end
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      vpend_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      vpend_q <= vpend_nxt;
      req_q   <= state_q == S_ISSUE;
      fd_q    <= fd_nxt;
      busy_q  <= state_nxt != S_IDLE;
      // base kept for a frame start deferred until the drain completes
      if (VSYNC_START && state_q != S_IDLE)
        base_q <= FRAME_BASE_ADDR;
      if (fstart) begin
        addr_q <= base_src;
        idx_q  <= '0;
      end else if (inc) begin
        addr_q <= addr_q + ADDR_WIDTH'(FETCH_BYTES);
        idx_q  <= idx_q + LINE_IDX_WIDTH'(1);
      end
    end
  end

  vga_buf_tracker u_trk (
    .clk         (M_AXI_ACLK),
    .rst_n       (M_AXI_ARESETN),
    .idle        (state_q == S_IDLE),
    .inc         (inc),
    .dec         (LINE_DONE),
    .drain       (drain),
    .clr         (CLR_UNDERRUN),
    .frame_start (fstart),
    .level       (BUF_LEVEL),
    .level_nxt   (level_nxt),
    .active_buf  (ACTIVE_BUF),
    .underrun    (UNDERRUN)
  );

  assign FETCH_REQ  = req_q;
  assign FETCH_ADDR = addr_q;
  assign LINE_IDX   = idx_q;
  assign FRAME_DONE = fd_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Bench for vga_fetch_scheduler: 4-line frames, 20-cycle master,
// step table plus address scoreboard.
module tb_vga_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ENABLE = 1'b0;
  logic [31:0] FRAME_BASE_ADDR = '0;
  logic        VSYNC_START = 1'b0;
  logic        LINE_DONE = 1'b0;
  logic        FETCH_DONE = 1'b0;
  logic        CLR_UNDERRUN = 1'b0;
  logic        FETCH_REQ;
  logic [31:0] FETCH_ADDR;
  logic        ACTIVE_BUF;
  logic [1:0]  BUF_LEVEL;
  logic [9:0]  LINE_IDX;
  logic        FRAME_DONE;
  logic        UNDERRUN;
  logic        BUSY;

  always #5 clk = ~clk;

  vga_fetch_scheduler #(
    .ADDR_WIDTH      (32),
    .FETCH_BYTES     (32'hD00),
    .LINES_PER_FRAME (4),
    .LINE_IDX_WIDTH  (10)
  ) dut (
    .M_AXI_ACLK      (clk),
    .M_AXI_ARESETN   (rst_n),
    .ENABLE          (ENABLE),
    .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
    .VSYNC_START     (VSYNC_START),
    .LINE_DONE       (LINE_DONE),
    .FETCH_DONE      (FETCH_DONE),
    .CLR_UNDERRUN    (CLR_UNDERRUN),
    .FETCH_REQ       (FETCH_REQ),
    .FETCH_ADDR      (FETCH_ADDR),
    .ACTIVE_BUF      (ACTIVE_BUF),
    .BUF_LEVEL       (BUF_LEVEL),
    .LINE_IDX        (LINE_IDX),
    .FRAME_DONE      (FRAME_DONE),
    .UNDERRUN        (UNDERRUN),
    .BUSY            (BUSY)
  );

  typedef struct {
    logic        ld;
    logic        clr;
    logic        vs;
    logic [31:0] base;
    int          nreq;
    int          ncyc;
    logic [1:0]  lvl;
    logic [9:0]  idx;
    logic        act;
    logic        und;
    int          fd;
    logic        lat;
  } step_t;

  step_t       tbl[10];
  step_t       s;
  logic [31:0] expq[$];
  logic [31:0] nxt;
  int          nchk = 0;
  int          nbad = 0;
  int          cyc = 0;
  int          cnt = 0;
  int          fd_cnt = 0;
  int          last_req = 0;
  int          ldc = 0;
  logic        found;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // one cycle: master model, scoreboard pop, frame-done count
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cnt > 0) begin
      cnt--;
      FETCH_DONE = (cnt == 0);
    end else begin
      FETCH_DONE = 1'b0;
    end
    if (FETCH_REQ) begin
      last_req = cyc;
      check("req_overlap", 64'(cnt != 0 || FETCH_DONE), 64'(0));
      if (expq.size() == 0)
        check("unexpected_req", 64'(FETCH_REQ), 64'(0));
      else
        check("req_addr", 64'(FETCH_ADDR), 64'(expq.pop_front()));
      cnt = 20;
    end
    if (FRAME_DONE) fd_cnt++;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h1000_0000, 2, 60, 2'd2, 10'd2, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h1000_0000, 1, 40, 2'd2, 10'd3, 1'b1, 1'b0, 0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h1000_0000, 1, 40, 2'd2, 10'd4, 1'b0, 1'b0, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h1000_0000, 0, 30, 2'd1, 10'd4, 1'b1, 1'b0, 1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h1000_0000, 0, 30, 2'd0, 10'd4, 1'b0, 1'b0, 1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h1000_0000, 0, 3,  2'd0, 10'd4, 1'b0, 1'b1, 1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h1000_0000, 0, 3,  2'd0, 10'd4, 1'b0, 1'b0, 1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h2000_0000, 1, 5,  2'd0, 10'd0, 1'b0, 1'b0, 1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h3000_0000, 1, 30, 2'd0, 10'd0, 1'b1, 1'b0, 1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h3000_0000, 1, 13, 2'd1, 10'd1, 1'b1, 1'b0, 1, 1'b0};
    nxt = '0;

    tick();
    check("reset_outs", 64'({FETCH_REQ, FETCH_ADDR, ACTIVE_BUF, BUF_LEVEL,
          LINE_IDX, FRAME_DONE, UNDERRUN, BUSY}), 64'(0));
    rst_n  = 1'b1;
    ENABLE = 1'b1;
    repeat (3) tick();
    check("busy_enabled", 64'(BUSY), 64'(1));
    check("lvl_enabled", 64'(BUF_LEVEL), 64'(0));

    for (int i = 0; i < 10; i++) begin
      s = tbl[i];
      FRAME_BASE_ADDR = s.base;
      if (s.vs) nxt = s.base;
      for (int k = 0; k < s.nreq; k++) begin
        expq.push_back(nxt);
        nxt += 32'hD00;
      end
      LINE_DONE    = s.ld;
      CLR_UNDERRUN = s.clr;
      VSYNC_START  = s.vs;
      ldc = cyc;
      tick();
      LINE_DONE    = 1'b0;
      CLR_UNDERRUN = 1'b0;
      VSYNC_START  = 1'b0;
      repeat (s.ncyc - 1) tick();
      check($sformatf("lvl[%0d]", i), 64'(BUF_LEVEL), 64'(s.lvl));
      check($sformatf("idx[%0d]", i), 64'(LINE_IDX), 64'(s.idx));
      check($sformatf("act[%0d]", i), 64'(ACTIVE_BUF), 64'(s.act));
      check($sformatf("und[%0d]", i), 64'(UNDERRUN), 64'(s.und));
      check($sformatf("fdone[%0d]", i), 64'(fd_cnt), 64'(s.fd));
      check($sformatf("busy[%0d]", i), 64'(BUSY), 64'(1));
      check($sformatf("req_missing[%0d]", i), 64'(expq.size()), 64'(0));
      if (s.lat)
        check("ld_to_req", 64'(last_req - ldc), 64'(2));
    end

    // fetch completion and line consumption in the same cycle
    expq.push_back(nxt);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (FETCH_DONE) found = 1'b1;
    end
    check("done_seen", 64'(found), 64'(1));
    LINE_DONE = 1'b1;
    tick();
    LINE_DONE = 1'b0;
    tick();
    tick();
    check("both_lvl", 64'(BUF_LEVEL), 64'(1));
    check("both_act", 64'(ACTIVE_BUF), 64'(0));
    check("both_idx", 64'(LINE_IDX), 64'(2));
    check("both_req", 64'(expq.size()), 64'(0));

    // reset while the next fetch is outstanding
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({FETCH_REQ, FETCH_ADDR, ACTIVE_BUF, BUF_LEVEL,
          LINE_IDX, FRAME_DONE, UNDERRUN, BUSY}), 64'(0));

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
